// File: rtl/video_axis_pkg.sv
// Shared types and constants for the AXI-Stream video monitor.
package video_axis_pkg;

    typedef enum logic [1:0] {
        RM_ALWAYS            = 2'd0,
        RM_RANDOM            = 2'd1,
        RM_READY_AFTER_VALID = 2'd2,
        RM_RESERVED          = 2'd3
    } ready_mode_e;

    // Bit positions inside err_flags
    localparam int ERR_SOF_MISS  = 0;
    localparam int ERR_SOF_UNEXP = 1;
    localparam int ERR_EOL_MISS  = 2;
    localparam int ERR_EOL_UNEXP = 3;
    localparam int ERR_STABLE    = 4;
    localparam int ERR_TIMEOUT   = 5;
    localparam int ERR_W         = 6;

    // 33-bit PRBS: shift left, feed back msb xor inverted tap 19
    localparam int PRBS_W     = 33;
    localparam int PRBS_TAP_A = 32;
    localparam int PRBS_TAP_B = 19;

    function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] p);
        return {p[PRBS_W-2:0], p[PRBS_TAP_A] ^ ~p[PRBS_TAP_B]};
    endfunction

endpackage

// File: rtl/axis_ready_gen.sv
// Backpressure generator: free-running PRBS plus mode select, registered gen_ready.
module axis_ready_gen
    import video_axis_pkg::*;
#(
    parameter logic [PRBS_W-1:0] PRBS_SEED = 33'd1246504138
) (
    input  logic       out_stream_aclk,
    input  logic       axi_resetn,
    input  logic [1:0] ready_mode,
    input  logic       s_tvalid,
    input  logic       beat,
    output logic       gen_ready
);

    logic [PRBS_W-1:0] prbs;

    // PRBS never stops (status clear does not touch it); gen_ready follows the selected mode
    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            prbs      <= PRBS_SEED;
            gen_ready <= 1'b0;
        end else begin
            prbs <= prbs_next(prbs);
            case (ready_mode_e'(ready_mode))
                RM_RANDOM:            gen_ready <= prbs[PRBS_TAP_A];
                RM_READY_AFTER_VALID: gen_ready <= s_tvalid & ~beat;
                default:              gen_ready <= 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/axis_video_monitor.sv
// In-line AXI-Stream video monitor: throttles the stream and checks SOF/EOL
// placement, handshake stability and tvalid activity, reporting sticky status.
module axis_video_monitor
    import video_axis_pkg::*;
#(
    parameter int                X_SIZE    = 480,
    parameter int                Y_SIZE    = 480,
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT   = 1000,
    parameter int                CNT_W     = 16,
    parameter logic [PRBS_W-1:0] PRBS_SEED = 33'd1246504138
) (
    input  logic                        out_stream_aclk,
    input  logic                        axi_resetn,
    input  logic [DATA_W-1:0]           s_tdata,
    input  logic                        s_tvalid,
    input  logic                        s_tuser,
    input  logic                        s_tlast,
    output logic                        s_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tuser,
    output logic                        m_tlast,
    input  logic                        m_tready,
    input  logic [1:0]                  ready_mode,
    input  logic                        clear,
    output logic [$clog2(X_SIZE)-1:0]   x_pos,
    output logic [$clog2(Y_SIZE)-1:0]   y_pos,
    output logic [CNT_W-1:0]            frame_count,
    output logic [CNT_W-1:0]            err_count,
    output logic [ERR_W-1:0]            err_flags
);

    localparam int XW = $clog2(X_SIZE);
    localparam int YW = $clog2(Y_SIZE);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [XW-1:0] X_LAST    = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(Y_SIZE - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    logic              gen_ready;
    logic              beat;
    logic              at_origin;
    logic              eol_pos;
    logic [XW-1:0]     x_eff, x_nxt;
    logic [YW-1:0]     y_eff, y_nxt;
    logic [ERR_W-1:0]  err_now;
    logic [IW-1:0]     idle_cnt;
    logic              stalled_q;
    logic [DATA_W-1:0] held_data;
    logic              held_user, held_last;

    assign s_tready = m_tready & gen_ready;
    assign m_tvalid = s_tvalid & gen_ready;
    assign m_tdata  = s_tdata;
    assign m_tuser  = s_tuser;
    assign m_tlast  = s_tlast;
    assign beat     = s_tvalid & s_tready;

    axis_ready_gen #(.PRBS_SEED(PRBS_SEED)) u_ready_gen (
        .out_stream_aclk (out_stream_aclk),
        .axi_resetn      (axi_resetn),
        .ready_mode      (ready_mode),
        .s_tvalid        (s_tvalid),
        .beat            (beat),
        .gen_ready       (gen_ready)
    );

    // Per-cycle error detection and next position; a tuser beat resyncs to (0,0) before the EOL check
    always_comb begin
        at_origin = (x_pos == '0) && (y_pos == '0);
        x_eff     = s_tuser ? '0 : x_pos;
        y_eff     = s_tuser ? '0 : y_pos;
        eol_pos   = (x_eff == X_LAST);

        err_now                = '0;
        err_now[ERR_SOF_MISS]  = beat & at_origin & ~s_tuser;
        err_now[ERR_SOF_UNEXP] = beat & ~at_origin & s_tuser;
        err_now[ERR_EOL_MISS]  = beat & eol_pos & ~s_tlast;
        err_now[ERR_EOL_UNEXP] = beat & ~eol_pos & s_tlast;
        err_now[ERR_STABLE]    = stalled_q & (~s_tvalid | (s_tdata != held_data) |
                                              (s_tuser != held_user) | (s_tlast != held_last));
        err_now[ERR_TIMEOUT]   = ~s_tvalid & (idle_cnt == IDLE_LAST);

        if (eol_pos || s_tlast) begin
            x_nxt = '0;
            y_nxt = (y_eff == Y_LAST) ? '0 : y_eff + 1'b1;
        end else begin
            x_nxt = x_eff + 1'b1;
            y_nxt = y_eff;
        end
    end

    // Expected position of the next word and count of accepted SOFs
    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            x_pos       <= '0;
            y_pos       <= '0;
            frame_count <= '0;
        end else if (clear) begin
            x_pos       <= '0;
            y_pos       <= '0;
            frame_count <= '0;
        end else if (beat) begin
            x_pos <= x_nxt;
            y_pos <= y_nxt;
            if (s_tuser) frame_count <= frame_count + 1'b1;
        end
    end

    // Sticky flags and saturating count of cycles with any error
    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            err_flags <= '0;
            err_count <= '0;
        end else if (clear) begin
            err_flags <= '0;
            err_count <= '0;
        end else begin
            err_flags <= err_flags | err_now;
            if ((|err_now) && (err_count != {CNT_W{1'b1}})) err_count <= err_count + 1'b1;
        end
    end

    // Idle watchdog: reloads to zero on expiry so it keeps firing every TIMEOUT idle cycles
    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            idle_cnt <= '0;
        end else if (clear || s_tvalid || (idle_cnt == IDLE_LAST)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Stall history: remember a stalled beat so the next cycle can be checked for stability
    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            stalled_q <= 1'b0;
            held_data <= '0;
            held_user <= 1'b0;
            held_last <= 1'b0;
        end else begin
            stalled_q <= clear ? 1'b0 : (s_tvalid & ~s_tready);
            held_data <= s_tdata;
            held_user <= s_tuser;
            held_last <= s_tlast;
        end
    end

endmodule

// File: tb/tb_axis_video_monitor.sv
// Scoreboard bench for axis_video_monitor with a small frame geometry.
module tb_axis_video_monitor;

    localparam logic [32:0] SEED = 33'd1246504138;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tuser, m_tlast;
    logic        m_tready = 1'b1;
    logic [1:0]  ready_mode = 2'd0;
    logic        clear = 1'b0;
    logic [1:0]  x_pos;
    logic [0:0]  y_pos;
    logic [15:0] frame_count, err_count;
    logic [5:0]  err_flags;

    always #5 clk = ~clk;

    axis_video_monitor #(.X_SIZE(4), .Y_SIZE(2), .DATA_W(32), .TIMEOUT(8), .CNT_W(16)) dut (
        .out_stream_aclk(clk), .axi_resetn(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tready(m_tready),
        .ready_mode(ready_mode), .clear(clear),
        .x_pos(x_pos), .y_pos(y_pos), .frame_count(frame_count), .err_count(err_count), .err_flags(err_flags)
    );

    typedef struct {
        string tag;
        int    fc, ec, fl, x, y;
        bit    rdy;
    } st_t;

    st_t         sq[$];
    logic [33:0] mq[$];
    int          checks = 0, errors = 0, stim_to = 0;
    bit          done = 1'b0, rnd_chk = 1'b0, rav_chk = 1'b0;
    logic [32:0] mprbs = SEED;
    logic        prev_msb = 1'b0;
    logic        rav_prev = 1'b0;

    // Reference PRBS, tracked from the seed
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mprbs    = SEED;
            prev_msb = 1'b0;
        end else begin
            prev_msb = mprbs[32];
            mprbs    = {mprbs[31:0], mprbs[32] ^ ~mprbs[19]};
        end
    end

    // Monitor: compares status records, output beats and ready patterns
    initial forever begin
        st_t         e;
        logic [33:0] b;
        logic        rav_exp;
        @(negedge clk);
        if (sq.size() > 0) begin
            e = sq.pop_front();
            checks++;
            if (frame_count !== 16'(e.fc) || err_count !== 16'(e.ec) || err_flags !== 6'(e.fl) ||
                x_pos !== 2'(e.x) || y_pos !== 1'(e.y)) begin
                errors++;
                $display("FAIL %s: got fc=%0d ec=%0d fl=%b x=%0d y=%0d, want fc=%0d ec=%0d fl=%b x=%0d y=%0d",
                         e.tag, frame_count, err_count, err_flags, x_pos, y_pos,
                         e.fc, e.ec, 6'(e.fl), e.x, e.y);
            end
            if (e.rdy) begin
                checks++;
                if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_ready: got s_tready=%b m_tvalid=%b, want 0 0", e.tag, s_tready, m_tvalid);
                end
            end
        end
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            checks++;
            if (mq.size() == 0) begin
                errors++;
                $display("FAIL m_beat: got unexpected beat %h, want none", m_tdata);
            end else begin
                b = mq.pop_front();
                if ({m_tdata, m_tuser, m_tlast} !== b) begin
                    errors++;
                    $display("FAIL m_beat: got %h/%b/%b, want %h/%b/%b",
                             m_tdata, m_tuser, m_tlast, b[33:2], b[1], b[0]);
                end
            end
        end
        if (rnd_chk) begin
            checks++;
            if (s_tready !== (m_tready & prev_msb)) begin
                errors++;
                $display("FAIL rnd_ready: got %b, want %b", s_tready, m_tready & prev_msb);
            end
        end
        rav_exp = m_tready & rav_prev;
        if (rav_chk) begin
            checks++;
            if (s_tready !== rav_exp) begin
                errors++;
                $display("FAIL rav_ready: got %b, want %b", s_tready, rav_exp);
            end
        end
        rav_prev = s_tvalid & ~s_tready;
        if (done) begin
            checks += 3;
            if (sq.size() != 0) begin errors++; $display("FAIL sq_drain: got %0d left, want 0", sq.size()); end
            if (mq.size() != 0) begin errors++; $display("FAIL mq_drain: got %0d left, want 0", mq.size()); end
            if (stim_to != 0)   begin errors++; $display("FAIL send_bound: got %0d expired, want 0", stim_to); end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input int fc, ec, fl, x, y, input bit rdy = 1'b0);
        st_t e;
        e.tag = tag; e.fc = fc; e.ec = ec; e.fl = fl; e.x = x; e.y = y; e.rdy = rdy;
        sq.push_back(e);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Present one beat and hold it stable until accepted
    task automatic send(input logic [31:0] d, input bit u, input bit l);
        logic got;
        got = 1'b0;
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        mq.push_back({d, u, l});
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            got = s_tready;
            tick();
            if (got) break;
        end
        if (!got) begin
            stim_to++;
            $display("FAIL send_timeout: got no transfer of %h, want transfer", d);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic frame(input int f);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                send(32'(f * 65536 + y * 256 + x), (x == 0 && y == 0), (x == 3));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_st("reset", 0, 0, 0, 0, 0, 1'b1);

        frame(1);
        frame(2);
        expect_st("two_frames", 2, 0, 0, 0, 0);

        do_clear();
        send(32'h100, 0, 0);
        expect_st("sof_miss", 0, 1, 1, 1, 0);
        send(32'h101, 0, 0); send(32'h102, 0, 0); send(32'h103, 0, 1);
        expect_st("sof_miss_cont", 0, 1, 1, 0, 1);

        do_clear();
        send(32'h200, 1, 0); send(32'h201, 0, 0); send(32'h202, 0, 0); send(32'h203, 0, 1);
        send(32'h210, 0, 0); send(32'h211, 0, 0);
        send(32'h212, 1, 0);
        expect_st("sof_unexp", 2, 1, 2, 1, 0);

        do_clear();
        send(32'h300, 1, 0); send(32'h301, 0, 0); send(32'h302, 0, 0); send(32'h303, 0, 0);
        expect_st("eol_miss", 1, 1, 4, 0, 1);
        send(32'h310, 0, 0); send(32'h311, 0, 1);
        expect_st("eol_unexp", 1, 2, 12, 0, 0);

        do_clear();
        send(32'h400, 1, 0); send(32'h401, 0, 0);
        send(32'h402, 1, 1);
        expect_st("sof_eol", 2, 1, 10, 0, 1);

        ready_mode = 2'd1;
        do_clear();
        m_tready = 1'b0;
        s_tdata = 32'h500; s_tuser = 1'b1; s_tlast = 1'b0; s_tvalid = 1'b1;
        tick();
        m_tready = 1'b1;
        send(32'h501, 1, 0);
        expect_st("stability", 1, 1, 16, 1, 0);
        rnd_chk = 1'b1;
        send(32'h502, 0, 0); send(32'h503, 0, 0); send(32'h504, 0, 1);
        send(32'h510, 0, 0); send(32'h511, 0, 0); send(32'h512, 0, 0); send(32'h513, 0, 1);
        expect_st("rnd_clean", 1, 1, 16, 0, 0);
        rnd_chk = 1'b0;

        ready_mode = 2'd2;
        do_clear();
        rav_chk = 1'b1;
        send(32'h600, 1, 0); send(32'h601, 0, 0); send(32'h602, 0, 0); send(32'h603, 0, 1);
        expect_st("rav", 1, 0, 0, 0, 1);
        rav_chk = 1'b0;
        ready_mode = 2'd0;

        send(32'h700, 1, 0); send(32'h701, 0, 0);
        rst_n = 1'b0;
        expect_st("rst_mid", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        s_tdata = 32'h702; s_tuser = 1'b1; s_tlast = 1'b0; s_tvalid = 1'b1;
        expect_st("rst_rel", 0, 0, 0, 0, 0, 1'b1);
        send(32'h702, 1, 0);
        expect_st("after_rst", 1, 0, 0, 1, 0);

        do_clear();
        repeat (7) tick();
        expect_st("idle7", 0, 0, 0, 0, 0);
        repeat (10) tick();
        expect_st("timeout", 0, 2, 32, 0, 0);

        s_tdata = 32'h800; s_tuser = 1'b1; s_tlast = 1'b0; s_tvalid = 1'b1;
        mq.push_back({32'h800, 1'b1, 1'b0});
        clear = 1'b1;
        tick();
        clear = 1'b0;
        s_tvalid = 1'b0;
        expect_st("clear", 0, 0, 0, 0, 0);

        tick();
        done = 1'b1;
    end

endmodule
